y86_instr_encoder: RTL and testbench
====================================

# y86_instr_encoder

Serialising instruction writer for the Y86-64 sequential processor's byte-addressed instruction memory. Accepts one decoded instruction per handshake (icode, ifun, rA, rB, valC) and emits its standard Y86-64 variable-length encoding (1, 2, 9 or 10 bytes), one byte per cycle, to the memory write port at an auto-incrementing pointer. It is the encoder counterpart of the fetch stage and loads test programs for it.

## Interface
- ADDR_W, 10, instruction memory address width; memory depth is 2^ADDR_W bytes
- BASE_ADDR, 0, write-pointer value after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder accepts an instruction this cycle
- icode, ifun, rA, rB  in  4 each  instruction fields
- valC  in  64  constant / displacement / destination
- ptr_load  in  1  load write pointer from ptr_value
- ptr_value  in  ADDR_W  new write-pointer value
- mem_we  out  1  byte write strobe
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  byte data
- wr_ptr  out  ADDR_W  next free byte address
- instr_done  out  1  one-cycle pulse with the last byte of an instruction
- err  out  1  one-cycle pulse: instruction rejected, nothing written

## Operation
- Lengths: halt(0), nop(1), ret(9) = 1; cmovXX(2), OPq(6), pushq(A), popq(B) = 2; jXX(7), call(8) = 9; irmovq(3), rmmovq(4), mrmovq(5) = 10.
- Byte 0 = {icode, ifun}. 2- and 10-byte forms: byte 1 = {rA, rB}. 10-byte: bytes 2..9 = valC little-endian. 9-byte: bytes 1..8 = valC little-endian.
- States: IDLE, EMIT. in_ready = (state == IDLE) && !ptr_load.
- IDLE, accept (in_valid && in_ready): latch fields, compute len. If icode > 4'hB or wr_ptr + len > 2^ADDR_W (compute in ADDR_W+1 bits, no wrap) → err pulse, stay IDLE. Otherwise → EMIT, idx = 0.
- EMIT: each cycle mem_we = 1, mem_addr = wr_ptr + idx, mem_wdata = byte[idx], idx++. On idx == len-1: instr_done = 1, wr_ptr += len, → IDLE.
- ptr_load in IDLE: wr_ptr = ptr_value next cycle, no accept that cycle. ptr_load in EMIT: ignored.
- in_valid with in_ready low: fields ignored; upstream holds them.

## Timing
- All outputs registered. Reset values: state IDLE, in_ready 1, mem_we 0, mem_addr 0, mem_wdata 0, wr_ptr BASE_ADDR, instr_done 0, err 0.
- Accept sampled at edge 0 → bytes written in cycles 1..len; instr_done in cycle len; in_ready high again in cycle len+1. Throughput: one instruction per len+1 cycles.
- Reject sampled at edge 0 → err high in cycle 1 only; in_ready stays high; mem_we never asserts.
- rst in EMIT: next cycle IDLE, mem_we 0, wr_ptr BASE_ADDR, no instr_done; already-written bytes remain in memory.
- Last byte may target address 2^ADDR_W - 1 exactly; wr_ptr then reads 0 (modulo ADDR_W).

## Configuration
- Y86_ENC_CHECK_EN defined: additional legality checks, failing ones give err with no write: ifun ≤ 6 for cmovXX/jXX, ifun ≤ 3 for OPq, ifun = 0 otherwise; rA = F for irmovq; rB = F for pushq/popq; rA, rB ≠ F where used as registers.
- Undefined: only the icode-range and overflow checks; ifun/rA/rB encoded verbatim.

## Structure
- Package y86_pkg: icode constants I_HALT..I_POPQ (4'h0..4'hB), RNONE = 4'hF, OPq/cond ifun constants, length constants; shared with fetch.
- Sub-module y86_instr_len: combinational icode/ifun/rA/rB → len (4 bits) and legal flag; macro-dependent checks live there.

## Test plan
- ptr 0, irmovq icode 3, rA F, rB 3, valC 0x0123456789ABCDEF → bytes 30 F3 EF CD AB 89 67 45 23 01 at 0..9 in cycles 1..10, instr_done in cycle 10, wr_ptr = 10.
- Back-to-back halt, nop, ret with in_valid held → 00 @10, 10 @11, 90 @12; in_ready low one cycle after each accept.
- call valC 0x40 → 80 40 00 00 00 00 00 00 00, 9 bytes, wr_ptr += 9.
- ptr_load 1020, rmmovq → err, no mem_we, wr_ptr 1020; then pushq rA 0 → A0 0F at 1020/1021, wr_ptr 1022.
- icode 0xC → err. OPq ifun 5: with Y86_ENC_CHECK_EN → err; without → 65 {rA,rB} written.
- rst asserted after 3 bytes of irmovq → mem_we 0 next cycle, wr_ptr = BASE_ADDR, no instr_done, in_ready 1.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encoding definitions, used by the instruction encoder and by
// the fetch stage.
//   - icode constants I_HALT..I_POPQ, the "no register" code RNONE
//   - OPq function codes and condition codes for cmovXX/jXX
//   - encoded lengths and the encoder state type
//   - y86_enc_byte(): byte idx of an instruction's standard encoding
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  // OPq function codes
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  // Condition codes for cmovXX / jXX
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] LEN_1  = 4'd1;
  localparam logic [3:0] LEN_2  = 4'd2;
  localparam logic [3:0] LEN_9  = 4'd9;
  localparam logic [3:0] LEN_10 = 4'd10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } enc_state_t;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
  } y86_instr_t;

  // Byte idx of the encoding of an instruction of length len.
  // Indices past the end of the instruction return 0.
  function automatic logic [7:0] y86_enc_byte(
    input y86_instr_t instr,
    input logic [3:0] len,
    input logic [3:0] idx
  );
    logic [7:0]  b;
    logic [3:0]  sh;
    logic [63:0] shifted;
    b       = 8'h00;
    sh      = 4'd0;
    shifted = 64'd0;
    if (idx == 4'd0) begin
      b = {instr.icode, instr.ifun};
    end else if ((len == LEN_2 || len == LEN_10) && idx == 4'd1) begin
      b = {instr.ra, instr.rb};
    end else if ((len == LEN_10 && idx <= 4'd9) || (len == LEN_9 && idx <= 4'd8)) begin
      // valC is little-endian after the opcode (and register byte if present)
      sh      = (len == LEN_10) ? idx - 4'd2 : idx - 4'd1;
      shifted = instr.valc >> {sh, 3'b000};
      b       = shifted[7:0];
    end
    return b;
  endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational length and legality decode for one Y86-64 instruction.
//   icode, ifun, rA, rB : instruction fields
//   len                 : encoded length in bytes (1, 2, 9 or 10)
//   legal               : instruction may be encoded
// Macro Y86_ENC_CHECK_EN: when defined, ifun and register fields are also
// validated; otherwise only the icode range is checked here.
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] ifun,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  output logic [3:0] len,
  output logic       legal
);

  logic icode_ok;
  logic fields_ok;

  always_comb begin
    len = LEN_1;
    case (icode)
      I_HALT, I_NOP, I_RET:                    len = LEN_1;
      I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ:        len = LEN_2;
      I_JXX, I_CALL:                           len = LEN_9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:            len = LEN_10;
      default:                                 len = LEN_1;
    endcase
  end

  assign icode_ok = (icode <= I_POPQ);

`ifdef Y86_ENC_CHECK_EN
  always_comb begin
    fields_ok = 1'b1;
    case (icode)
      I_CMOVXX:           fields_ok = (ifun <= C_G) && (rA != RNONE) && (rB != RNONE);
      I_JXX:              fields_ok = (ifun <= C_G);
      I_OPQ:              fields_ok = (ifun <= ALU_XOR) && (rA != RNONE) && (rB != RNONE);
      I_IRMOVQ:           fields_ok = (ifun == 4'h0) && (rA == RNONE) && (rB != RNONE);
      I_RMMOVQ, I_MRMOVQ: fields_ok = (ifun == 4'h0) && (rA != RNONE) && (rB != RNONE);
      I_PUSHQ, I_POPQ:    fields_ok = (ifun == 4'h0) && (rA != RNONE) && (rB == RNONE);
      default:            fields_ok = (ifun == 4'h0);
    endcase
  end
`else
  // Fields are encoded verbatim; only the icode range matters.
  logic unused_fields;
  assign unused_fields = ^{ifun, rA, rB};
  assign fields_ok     = 1'b1;
`endif

  assign legal = icode_ok && fields_ok;

endmodule

// File: rtl/y86_instr_encoder.sv
// Serialising Y86-64 instruction writer. Accepts one instruction per
// in_valid/in_ready handshake and writes its 1/2/9/10-byte encoding, one byte
// per cycle, to a byte-wide memory port at an auto-incrementing pointer.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : instruction handshake
//   icode..valC         : instruction fields
//   ptr_load/ptr_value  : reload write pointer (honoured only while idle)
//   mem_we/addr/wdata   : memory write port (registered)
//   wr_ptr              : next free byte address
//   instr_done          : pulse alongside the last byte of an instruction
//   err                 : pulse when an instruction is rejected (no writes)
// Macro Y86_ENC_CHECK_EN enables ifun/register legality checks.
module y86_instr_encoder
  import y86_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  input  logic              ptr_load,
  input  logic [ADDR_W-1:0] ptr_value,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              instr_done,
  output logic              err
);

  localparam logic [ADDR_W:0] MEM_SIZE = {1'b1, {ADDR_W{1'b0}}};

  enc_state_t        state_reg,     state_next;
  y86_instr_t        instr_reg,     instr_next;
  logic [3:0]        len_reg,       len_next;
  logic [3:0]        cnt_reg,       cnt_next;   // bytes issued so far
  logic [ADDR_W-1:0] wr_ptr_reg,    wr_ptr_next;
  logic              mem_we_reg,    mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg,  mem_addr_next;
  logic [7:0]        mem_wdata_reg, mem_wdata_next;
  logic              done_reg,      done_next;
  logic              err_reg,       err_next;

  logic [3:0]        len_w;
  logic              legal_w;
  logic [ADDR_W:0]   end_addr;
  logic              fits;
  logic [7:0]        emit_byte [0:15];

  y86_instr_len u_len (
    .icode (icode),
    .ifun  (ifun),
    .rA    (rA),
    .rB    (rB),
    .len   (len_w),
    .legal (legal_w)
  );

  // One past the last byte, in ADDR_W+1 bits so a wrap is detectable.
  assign end_addr = {1'b0, wr_ptr_reg} + {{(ADDR_W-3){1'b0}}, len_w};
  assign fits     = (end_addr <= MEM_SIZE);

  // All byte lanes of the latched instruction; cnt_reg selects one per cycle.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
      assign emit_byte[gi] = y86_enc_byte(instr_reg, len_reg, 4'(gi));
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    instr_next     = instr_reg;
    len_next       = len_reg;
    cnt_next       = cnt_reg;
    wr_ptr_next    = wr_ptr_reg;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (ptr_load) begin
          wr_ptr_next = ptr_value;
        end else if (in_valid) begin
          if (!legal_w || !fits) begin
            err_next = 1'b1;
          end else begin
            // Byte 0 goes out straight from the inputs so the first write
            // lands in the cycle right after the accept.
            state_next     = S_EMIT;
            instr_next     = '{icode: icode, ifun: ifun, ra: rA, rb: rB, valc: valC};
            len_next       = len_w;
            cnt_next       = 4'd1;
            mem_we_next    = 1'b1;
            mem_addr_next  = wr_ptr_reg;
            mem_wdata_next = {icode, ifun};
            done_next      = (len_w == LEN_1);
          end
        end
      end
      S_EMIT: begin
        if (cnt_reg == len_reg) begin
          // Last byte is on the port this cycle; advance the pointer now.
          state_next  = S_IDLE;
          wr_ptr_next = wr_ptr_reg + ADDR_W'(len_reg);
        end else begin
          mem_we_next    = 1'b1;
          mem_addr_next  = wr_ptr_reg + ADDR_W'(cnt_reg);
          mem_wdata_next = emit_byte[cnt_reg];
          done_next      = (cnt_reg == len_reg - 4'd1);
          cnt_next       = cnt_reg + 4'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      instr_reg     <= '0;
      len_reg       <= 4'd0;
      cnt_reg       <= 4'd0;
      wr_ptr_reg    <= ADDR_W'(BASE_ADDR);
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= 8'h00;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      instr_reg     <= instr_next;
      len_reg       <= len_next;
      cnt_reg       <= cnt_next;
      wr_ptr_reg    <= wr_ptr_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  assign in_ready   = (state_reg == S_IDLE) && !ptr_load;
  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign wr_ptr     = wr_ptr_reg;
  assign instr_done = done_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Scoreboard bench for y86_instr_encoder: stimulus pushes expected writes and
// error pulses into a queue, a negedge monitor pops and compares them.
module tb_y86_instr_encoder;

  localparam int ADDR_W    = 10;
  localparam int BASE_ADDR = 0;
  localparam int MEM_BYTES = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        icode, ifun, rA, rB;
  logic [63:0]       valC;
  logic              ptr_load;
  logic [ADDR_W-1:0] ptr_value;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [ADDR_W-1:0] wr_ptr;
  logic              instr_done;
  logic              err;

  y86_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .icode      (icode),
    .ifun       (ifun),
    .rA         (rA),
    .rB         (rB),
    .valC       (valC),
    .ptr_load   (ptr_load),
    .ptr_value  (ptr_value),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .wr_ptr     (wr_ptr),
    .instr_done (instr_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int addr;
    int data;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   model_ptr = BASE_ADDR;

  // ---------------- reference model ----------------
  function automatic int model_len(input bit [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 1;
    endcase
  endfunction

  function automatic bit model_legal(input bit [3:0] ic, fn, ra, rb);
    if (ic > 4'hB) return 1'b0;
`ifdef Y86_ENC_CHECK_EN
    case (ic)
      4'h2:       return fn <= 6 && ra != 15 && rb != 15;
      4'h7:       return fn <= 6;
      4'h6:       return fn <= 3 && ra != 15 && rb != 15;
      4'h3:       return fn == 0 && ra == 15 && rb != 15;
      4'h4, 4'h5: return fn == 0 && ra != 15 && rb != 15;
      4'hA, 4'hB: return fn == 0 && ra != 15 && rb == 15;
      default:    return fn == 0;
    endcase
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL write: unexpected write addr %0d data %02h", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (e.is_err || int'(mem_addr) != e.addr || int'(mem_wdata) != e.data ||
            instr_done != e.done) begin
          failures++;
          $display("FAIL write: got addr %0d data %02h done %0b, expected err %0b addr %0d data %02h done %0b",
                   mem_addr, mem_wdata, instr_done, e.is_err, e.addr, e.data, e.done);
        end
      end
    end
    if (err) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL err: unexpected err pulse");
      end else begin
        e = exp_q.pop_front();
        if (!e.is_err) begin
          failures++;
          $display("FAIL err: got err pulse, expected write addr %0d data %02h", e.addr, e.data);
        end
      end
    end
    if (instr_done && !mem_we) begin
      checks++;
      failures++;
      $display("FAIL done: instr_done without mem_we");
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input bit [3:0] ic, input bit [3:0] fn, input bit [3:0] ra,
                      input bit [3:0] rb, input bit [63:0] vc);
    int   guard;
    int   len;
    bit   ok;
    bit [7:0] bytes_q[$];
    exp_t e;
    icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready) begin
      @(negedge clk); #1;
      guard++;
      if (guard > 50) begin
        check("accept_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        return;
      end
    end
    len = model_len(ic);
    ok  = model_legal(ic, fn, ra, rb) && (model_ptr + len <= MEM_BYTES);
    if (!ok) begin
      e = '{is_err: 1'b1, addr: 0, data: 0, done: 1'b0};
      exp_q.push_back(e);
      $display("txn icode=%h ifun=%h rA=%h rB=%h valC=%016h ptr=%0d -> reject",
               ic, fn, ra, rb, vc, model_ptr);
    end else begin
      bytes_q.push_back({ic, fn});
      if (len == 2 || len == 10) bytes_q.push_back({ra, rb});
      if (len >= 9) for (int i = 0; i < 8; i++) bytes_q.push_back(vc[8*i +: 8]);
      for (int i = 0; i < len; i++) begin
        e = '{is_err: 1'b0, addr: (model_ptr + i) % MEM_BYTES, data: int'(bytes_q[i]),
              done: (i == len - 1)};
        exp_q.push_back(e);
      end
      $display("txn icode=%h ifun=%h rA=%h rB=%h valC=%016h ptr=%0d -> %0d bytes",
               ic, fn, ra, rb, vc, model_ptr, len);
      model_ptr = (model_ptr + len) % MEM_BYTES;
    end
    @(posedge clk);
    @(negedge clk); #1;
    check("ready_after_accept", 64'(in_ready), 64'(!ok));
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || !in_ready) && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 100) check("idle_timeout", 64'(exp_q.size()), 64'd0);
    check("wr_ptr", 64'(wr_ptr), 64'(model_ptr));
  endtask

  task automatic load_ptr(input int v);
    in_valid  = 1'b0;
    ptr_load  = 1'b1;
    ptr_value = ADDR_W'(v);
    #1;
    check("ready_during_load", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    ptr_load  = 1'b0;
    model_ptr = v;
    $display("txn ptr_load %0d", v);
    check("wr_ptr_loaded", 64'(wr_ptr), 64'(v));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; ptr_load = 1'b0; ptr_value = '0;
    icode = 4'h0; ifun = 4'h0; rA = 4'h0; rB = 4'h0; valC = 64'd0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",   64'(in_ready),   64'd1);
    check("rst_mem_we",     64'(mem_we),     64'd0);
    check("rst_mem_addr",   64'(mem_addr),   64'd0);
    check("rst_mem_wdata",  64'(mem_wdata),  64'd0);
    check("rst_wr_ptr",     64'(wr_ptr),     64'(BASE_ADDR));
    check("rst_instr_done", 64'(instr_done), 64'd0);
    check("rst_err",        64'(err),        64'd0);
    rst = 1'b0;
    #1;

    // irmovq $0x0123456789ABCDEF, %rbx
    send(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF);
    wait_idle();

    // halt, nop, ret back to back with in_valid held
    send(4'h0, 4'h0, 4'hF, 4'hF, 64'd0);
    send(4'h1, 4'h0, 4'hF, 4'hF, 64'd0);
    send(4'h9, 4'h0, 4'hF, 4'hF, 64'd0);
    wait_idle();

    // call 0x40
    send(4'h8, 4'h0, 4'hF, 4'hF, 64'h40);
    wait_idle();

    // overflow reject near the top, then a 2-byte push that fits
    load_ptr(1020);
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h10);
    wait_idle();
    send(4'hA, 4'h0, 4'h0, 4'hF, 64'd0);
    wait_idle();

    // last byte lands exactly on the top address, pointer wraps to 0
    load_ptr(MEM_BYTES - 10);
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'hDEADBEEFCAFEF00D);
    wait_idle();

    // illegal icode; OPq with out-of-range ifun
    send(4'hC, 4'h0, 4'h1, 4'h2, 64'd0);
    wait_idle();
    send(4'h6, 4'h5, 4'h1, 4'h2, 64'd0);
    wait_idle();

    // reset after the third byte of an irmovq
    send(4'h3, 4'h0, 4'hF, 4'h1, 64'h1122334455667788);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk); #1;
    check("rst_emit_mem_we",     64'(mem_we),     64'd0);
    check("rst_emit_instr_done", 64'(instr_done), 64'd0);
    check("rst_emit_wr_ptr",     64'(wr_ptr),     64'(BASE_ADDR));
    check("rst_emit_in_ready",   64'(in_ready),   64'd1);
    rst = 1'b0;
    model_ptr = BASE_ADDR;
    $display("txn reset during emit");

    // randomized instructions
    for (int n = 0; n < 80; n++) begin
      bit [3:0] ic, fn;
      if ($urandom_range(0, 7) == 0) begin
        wait_idle();
        load_ptr(int'($urandom_range(MEM_BYTES - 24, MEM_BYTES - 1)));
      end
      ic = 4'($urandom_range(0, 13));
      fn = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 7));
      send(ic, fn, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           {32'($urandom), 32'($urandom)});
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
